// File: rtl/dvp_pixel_packer.sv
// -----------------------------------------------------------------------------
// dvp_pixel_packer
//   Captures 8-bit DVP camera bytes, pairs them into 16-bit pixels and packs
//   two pixels into one 32-bit word for a downstream FIFO.  Frame capture is
//   armed by cap_enable and always starts on a full vsync cycle.
//
// Ports
//   clk, reset_n   : pixel clock (rising edge), asynchronous active-low reset
//   dvp_data/href/vsync : camera byte, line-valid, frame-sync
//   cap_enable     : capture request level
//   byte_swap      : 0 -> first byte of a pixel is bits 15:8, 1 -> bits 7:0
//   out_data/out_valid/out_ready : packed word, one-cycle strobe, FIFO not full
//   frame_start/frame_done : one-cycle frame pulses
//   overflow/ovf_clear : sticky dropped-word flag and its clear
//   line_width/frame_lines : pixels of last line, lines of last frame
// -----------------------------------------------------------------------------
module dvp_pixel_packer #(
  parameter int PIXCNT_W  = 12,
  parameter int LINECNT_W = 11
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           dvp_data,
  input  logic                 dvp_href,
  input  logic                 dvp_vsync,
  input  logic                 cap_enable,
  input  logic                 byte_swap,
  output logic [31:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_start,
  output logic                 frame_done,
  output logic                 overflow,
  input  logic                 ovf_clear,
  output logic [PIXCNT_W-1:0]  line_width,
  output logic [LINECNT_W-1:0] frame_lines
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_VBLANK = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t               r_state;
  logic [7:0]           r_data_s1;
  logic                 r_href_s1;
  logic                 r_vsync_s1;
  logic                 r_href_d;
  logic                 r_vsync_d;
  logic                 r_byte_ph;
  logic                 r_pix_ph;
  logic [7:0]           r_first_byte;
  logic [15:0]          r_pix0;
  logic [PIXCNT_W-1:0]  r_pix_cnt;
  logic [LINECNT_W-1:0] r_line_cnt;
  logic [31:0]          r_out_data;
  logic                 r_out_valid;
  logic                 r_frame_start;
  logic                 r_frame_done;
  logic                 r_overflow;
  logic [PIXCNT_W-1:0]  r_line_width;
  logic [LINECNT_W-1:0] r_frame_lines;

  logic                 w_href_rise;
  logic                 w_href_fall;
  logic                 w_vsync_rise;
  logic                 w_vsync_fall;
  logic                 w_byte_ph;
  logic [15:0]          w_pixel;
  logic [PIXCNT_W-1:0]  w_pix_cnt_inc;
  logic [LINECNT_W-1:0] w_line_cnt_inc;

  // Edges are taken between the S1 sample and the previous S1 sample.
  assign w_href_rise  = r_href_s1 & ~r_href_d;
  assign w_href_fall  = ~r_href_s1 & r_href_d;
  assign w_vsync_rise = r_vsync_s1 & ~r_vsync_d;
  assign w_vsync_fall = ~r_vsync_s1 & r_vsync_d;

  // A new line always starts on the first byte of a pixel.
  assign w_byte_ph = w_href_rise ? 1'b0 : r_byte_ph;
  assign w_pixel   = byte_swap ? {r_data_s1, r_first_byte} : {r_first_byte, r_data_s1};

  // Saturating counter increments.
  assign w_pix_cnt_inc  = (r_pix_cnt == {PIXCNT_W{1'b1}}) ? r_pix_cnt : r_pix_cnt + PIXCNT_W'(1);
  assign w_line_cnt_inc = (r_line_cnt == {LINECNT_W{1'b1}}) ? r_line_cnt : r_line_cnt + LINECNT_W'(1);

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign overflow    = r_overflow;
  assign line_width  = r_line_width;
  assign frame_lines = r_frame_lines;

  // Input stage, capture FSM, pixel packing, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_data_s1     <= 8'h00;
      r_href_s1     <= 1'b0;
      r_vsync_s1    <= 1'b0;
      r_href_d      <= 1'b0;
      r_vsync_d     <= 1'b0;
      r_byte_ph     <= 1'b0;
      r_pix_ph      <= 1'b0;
      r_first_byte  <= 8'h00;
      r_pix0        <= 16'h0000;
      r_pix_cnt     <= '0;
      r_line_cnt    <= '0;
      r_out_data    <= 32'h0000_0000;
      r_out_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_overflow    <= 1'b0;
      r_line_width  <= '0;
      r_frame_lines <= '0;
    end else begin
      r_data_s1     <= dvp_data;
      r_href_s1     <= dvp_href;
      r_vsync_s1    <= dvp_vsync;
      r_href_d      <= r_href_s1;
      r_vsync_d     <= r_vsync_s1;
      r_out_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;

      // A strobe the FIFO cannot take is lost; setting wins over clearing.
      if (r_out_valid && !out_ready) begin
        r_overflow <= 1'b1;
      end else if (ovf_clear) begin
        r_overflow <= 1'b0;
      end else begin
        r_overflow <= r_overflow;
      end

      case (r_state)
        ST_IDLE: begin
          if (cap_enable) r_state <= ST_SYNC;
          else            r_state <= ST_IDLE;
        end
        ST_SYNC: begin
          if (!cap_enable)       r_state <= ST_IDLE;
          else if (w_vsync_rise) r_state <= ST_VBLANK;
          else                   r_state <= ST_SYNC;
        end
        ST_VBLANK: begin
          if (!cap_enable) begin
            r_state <= ST_IDLE;
          end else if (w_vsync_fall) begin
            r_state       <= ST_ACTIVE;
            r_frame_start <= 1'b1;
            r_line_cnt    <= '0;
            r_pix_cnt     <= '0;
            r_byte_ph     <= 1'b0;
            r_pix_ph      <= 1'b0;
          end else begin
            r_state <= ST_VBLANK;
          end
        end
        ST_ACTIVE: begin
          // cap_enable is only consulted at the end of the frame.
          if (w_vsync_rise) begin
            r_frame_done  <= 1'b1;
            r_frame_lines <= r_line_cnt;
            r_byte_ph     <= 1'b0;
            r_pix_ph      <= 1'b0;
            r_state       <= cap_enable ? ST_VBLANK : ST_IDLE;
          end else if (r_href_s1) begin
            if (!w_byte_ph) begin
              r_first_byte <= r_data_s1;
              r_byte_ph    <= 1'b1;
              if (w_href_rise) r_pix_ph <= 1'b0;
            end else begin
              r_byte_ph <= 1'b0;
              r_pix_cnt <= w_pix_cnt_inc;
              if (!r_pix_ph) begin
                r_pix0   <= w_pixel;
                r_pix_ph <= 1'b1;
              end else begin
                r_out_data  <= {w_pixel, r_pix0};
                r_out_valid <= 1'b1;
                r_pix_ph    <= 1'b0;
              end
            end
          end else if (w_href_fall) begin
            // Flush a lone pending pixel; a dangling odd byte is dropped.
            if (r_pix_ph) begin
              r_out_data  <= {16'h0000, r_pix0};
              r_out_valid <= 1'b1;
            end
            r_line_width <= r_pix_cnt;
            r_pix_cnt    <= '0;
            r_line_cnt   <= w_line_cnt_inc;
            r_byte_ph    <= 1'b0;
            r_pix_ph     <= 1'b0;
          end else begin
            r_state <= ST_ACTIVE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dvp_pixel_packer.sv
module tb_dvp_pixel_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  dvp_data;
  logic        dvp_href;
  logic        dvp_vsync;
  logic        cap_enable;
  logic        byte_swap;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        frame_start;
  logic        frame_done;
  logic        overflow;
  logic        ovf_clear;
  logic [11:0] line_width;
  logic [10:0] frame_lines;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_valid  = 0;
  int n_fs     = 0;
  int n_fd     = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          obs_t[$];

  dvp_pixel_packer #(.PIXCNT_W(12), .LINECNT_W(11)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .dvp_data    (dvp_data),
    .dvp_href    (dvp_href),
    .dvp_vsync   (dvp_vsync),
    .cap_enable  (cap_enable),
    .byte_swap   (byte_swap),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .ovf_clear   (ovf_clear),
    .line_width  (line_width),
    .frame_lines (frame_lines)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: the words the FIFO would actually take, with their cycle.
  always @(negedge clk) begin
    if (out_valid) begin
      n_valid++;
      if (out_ready) begin
        obs_q.push_back(out_data);
        obs_t.push_back(cyc);
      end
    end
    if (frame_start) n_fs++;
    if (frame_done)  n_fd++;
  end

  task automatic cyc_step();
    @(posedge clk);
    #1;
  endtask

  task automatic vsync_pulse();
    dvp_vsync = 1'b1;
    repeat (3) cyc_step();
    dvp_vsync = 1'b0;
    repeat (3) cyc_step();
  endtask

  // One href line of n bytes base + i*step; out_ready is held low (and
  // ovf_clear driven to clr) from byte drop_at for three bytes.
  task automatic drive_line(input int n, input logic [7:0] base, input logic [7:0] step,
                            input int drop_at, input logic clr,
                            output int t_last, output int t_fall);
    t_last = 0;
    for (int i = 0; i < n; i++) begin
      if (i == drop_at) begin
        out_ready = 1'b0;
        ovf_clear = clr;
      end
      if (i == drop_at + 3) begin
        out_ready = 1'b1;
        ovf_clear = 1'b0;
      end
      dvp_href = 1'b1;
      dvp_data = 8'(base + i * step);
      t_last   = cyc;
      cyc_step();
    end
    dvp_href  = 1'b0;
    dvp_data  = 8'h00;
    out_ready = 1'b1;
    ovf_clear = 1'b0;
    t_fall    = cyc;
    repeat (4) cyc_step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; dvp_data = 8'h00; dvp_href = 1'b0; dvp_vsync = 1'b0;
    cap_enable = 1'b0; byte_swap = 1'b0; out_ready = 1'b1; ovf_clear = 1'b0;
    repeat (3) cyc_step();
    checks++;
    if ({out_valid, frame_start, frame_done, overflow} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags: got %b want 0000", {out_valid, frame_start, frame_done, overflow});
    end
    checks++;
    if ({out_data, line_width, frame_lines} !== 55'd0) begin
      failures++; $display("FAIL reset_data: got %h/%0d/%0d want 0/0/0", out_data, line_width, frame_lines);
    end
    reset_n = 1'b1;
    repeat (2) cyc_step();
  endtask

  task automatic test_basic();
    int t_last, t_fall, fs0, fd0, v0, ot;
    logic [31:0] o;
    cap_enable = 1'b1;
    cyc_step();
    fs0 = n_fs;
    vsync_pulse();
    checks++;
    if (n_fs !== fs0 + 1) begin failures++; $display("FAIL basic_frame_start: got %0d pulses want 1", n_fs - fs0); end
    exp_q.push_back(32'h3344_1122);
    exp_q.push_back(32'h7788_5566);
    v0 = n_valid; fd0 = n_fd;
    drive_line(8, 8'h11, 8'h11, -1, 1'b0, t_last, t_fall);
    checks++;
    if (obs_q.size() != 2) begin
      failures++; $display("FAIL basic_count: got %0d words want 2", obs_q.size());
      obs_q.delete(); obs_t.delete(); exp_q.delete();
    end else begin
      o = obs_q.pop_front(); ot = obs_t.pop_front();
      checks++;
      if (o !== exp_q.pop_front()) begin failures++; $display("FAIL basic_word0: got %h want 33441122", o); end
      o = obs_q.pop_front(); ot = obs_t.pop_front();
      checks++;
      if (o !== exp_q.pop_front()) begin failures++; $display("FAIL basic_word1: got %h want 77885566", o); end
      checks++;
      if (ot !== t_last + 2) begin failures++; $display("FAIL basic_latency: got %0d cycles want 2", ot - t_last); end
    end
    checks++;
    if (n_valid !== v0 + 2) begin failures++; $display("FAIL basic_strobe_len: got %0d valid cycles want 2", n_valid - v0); end
    checks++;
    if (out_data !== 32'h7788_5566) begin failures++; $display("FAIL basic_hold: got %h want 77885566", out_data); end
    checks++;
    if (line_width !== 12'd4) begin failures++; $display("FAIL basic_line_width: got %0d want 4", line_width); end
    vsync_pulse();
    checks++;
    if (n_fd !== fd0 + 1) begin failures++; $display("FAIL basic_frame_done: got %0d pulses want 1", n_fd - fd0); end
    checks++;
    if (frame_lines !== 11'd1) begin failures++; $display("FAIL basic_frame_lines: got %0d want 1", frame_lines); end
  endtask

  task automatic test_swap();
    int t_last, t_fall;
    logic [31:0] e, o;
    byte_swap = 1'b1;
    exp_q.push_back(32'h4433_2211);
    exp_q.push_back(32'h8877_6655);
    drive_line(8, 8'h11, 8'h11, -1, 1'b0, t_last, t_fall);
    byte_swap = 1'b0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL swap_word: got none want %h", e); end
      else begin
        o = obs_q.pop_front(); void'(obs_t.pop_front());
        if (o !== e) begin failures++; $display("FAIL swap_word: got %h want %h", o, e); end
      end
    end
    vsync_pulse();
  endtask

  task automatic test_odd();
    int t_last, t_fall, ot;
    logic [31:0] e, o;
    exp_q.push_back(32'hA3A4_A1A2);
    exp_q.push_back(32'h0000_A5A6);
    drive_line(6, 8'hA1, 8'h01, -1, 1'b0, t_last, t_fall);
    ot = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL odd6_word: got none want %h", e); end
      else begin
        o = obs_q.pop_front(); ot = obs_t.pop_front();
        if (o !== e) begin failures++; $display("FAIL odd6_word: got %h want %h", o, e); end
      end
    end
    checks++;
    if (ot !== t_fall + 2) begin failures++; $display("FAIL odd6_flush_time: got %0d want %0d", ot, t_fall + 2); end
    checks++;
    if (line_width !== 12'd3) begin failures++; $display("FAIL odd6_width: got %0d want 3", line_width); end
    exp_q.push_back(32'hA3A4_A1A2);
    exp_q.push_back(32'h0000_A5A6);
    drive_line(7, 8'hA1, 8'h01, -1, 1'b0, t_last, t_fall);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL odd7_word: got none want %h", e); end
      else begin
        o = obs_q.pop_front(); void'(obs_t.pop_front());
        if (o !== e) begin failures++; $display("FAIL odd7_word: got %h want %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL odd7_extra: got %0d extra words want 0", obs_q.size()); obs_q.delete(); obs_t.delete(); end
    checks++;
    if (line_width !== 12'd3) begin failures++; $display("FAIL odd7_width: got %0d want 3", line_width); end
    vsync_pulse();
    checks++;
    if (frame_lines !== 11'd2) begin failures++; $display("FAIL odd_frame_lines: got %0d want 2", frame_lines); end
  endtask

  task automatic test_overflow();
    int t_last, t_fall;
    logic [31:0] e, o;
    exp_q.push_back(32'h7788_5566);
    drive_line(8, 8'h11, 8'h11, 3, 1'b0, t_last, t_fall);
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b want 1", overflow); end
    exp_q.push_back(32'h7788_5566);
    drive_line(8, 8'h11, 8'h11, 3, 1'b1, t_last, t_fall);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL ovf_word: got none want %h", e); end
      else begin
        o = obs_q.pop_front(); void'(obs_t.pop_front());
        if (o !== e) begin failures++; $display("FAIL ovf_word: got %h want %h", o, e); end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_beats_clear: got %b want 1", overflow); end
    ovf_clear = 1'b1;
    cyc_step();
    ovf_clear = 1'b0;
    cyc_step();
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    vsync_pulse();
  endtask

  task automatic test_enable();
    int t_last, t_fall, fs0, fd0;
    logic [31:0] e, o;
    cap_enable = 1'b0;
    exp_q.push_back(32'h0507_0103);
    exp_q.push_back(32'h0D0F_090B);
    drive_line(8, 8'h01, 8'h02, -1, 1'b0, t_last, t_fall);
    fs0 = n_fs; fd0 = n_fd;
    vsync_pulse();
    checks++;
    if (n_fd !== fd0 + 1 || n_fs !== fs0) begin
      failures++; $display("FAIL en_drop_frame: got done=%0d start=%0d want 1/0", n_fd - fd0, n_fs - fs0);
    end
    checks++;
    if (frame_lines !== 11'd1) begin failures++; $display("FAIL en_drop_lines: got %0d want 1", frame_lines); end
    drive_line(8, 8'h01, 8'h02, -1, 1'b0, t_last, t_fall);
    cap_enable = 1'b1;
    cyc_step();
    drive_line(8, 8'h01, 8'h02, -1, 1'b0, t_last, t_fall);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL en_word: got none want %h", e); end
      else begin
        o = obs_q.pop_front(); void'(obs_t.pop_front());
        if (o !== e) begin failures++; $display("FAIL en_word: got %h want %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0 || n_fs !== fs0) begin
      failures++; $display("FAIL en_idle_quiet: got %0d words %0d starts want 0/0", obs_q.size(), n_fs - fs0);
      obs_q.delete(); obs_t.delete();
    end
    vsync_pulse();
    exp_q.push_back(32'h0507_0103);
    exp_q.push_back(32'h0D0F_090B);
    drive_line(8, 8'h01, 8'h02, -1, 1'b0, t_last, t_fall);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL en_resume_word: got none want %h", e); end
      else begin
        o = obs_q.pop_front(); void'(obs_t.pop_front());
        if (o !== e) begin failures++; $display("FAIL en_resume_word: got %h want %h", o, e); end
      end
    end
    vsync_pulse();
  endtask

  task automatic test_reset_midline();
    int t_last, t_fall;
    logic [31:0] e, o;
    for (int i = 0; i < 3; i++) begin
      dvp_href = 1'b1; dvp_data = 8'(8'h11 * (i + 1)); cyc_step();
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, frame_start, frame_done, overflow} !== 4'b0000 || out_data !== 32'h0 ||
        line_width !== 12'd0 || frame_lines !== 11'd0) begin
      failures++; $display("FAIL rst_mid_outputs: got %h/%0d/%0d/%b want 0/0/0/0", out_data, line_width, frame_lines, overflow);
    end
    cyc_step();
    reset_n = 1'b1;
    for (int i = 3; i < 8; i++) begin
      dvp_href = 1'b1; dvp_data = 8'(8'h11 * (i + 1)); cyc_step();
    end
    dvp_href = 1'b0;
    repeat (4) cyc_step();
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL rst_mid_quiet: got %0d words want 0", obs_q.size()); obs_q.delete(); obs_t.delete(); end
    vsync_pulse();
    exp_q.push_back(32'h0507_0103);
    exp_q.push_back(32'h0D0F_090B);
    drive_line(8, 8'h01, 8'h02, -1, 1'b0, t_last, t_fall);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL rst_resume_word: got none want %h", e); end
      else begin
        o = obs_q.pop_front(); void'(obs_t.pop_front());
        if (o !== e) begin failures++; $display("FAIL rst_resume_word: got %h want %h", o, e); end
      end
    end
    vsync_pulse();
    checks++;
    if (frame_lines !== 11'd1) begin failures++; $display("FAIL rst_resume_lines: got %0d want 1", frame_lines); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_swap();
    test_odd();
    test_overflow();
    test_enable();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dvp_pixel_packer.md
DVP_PIXEL_PACKER -- requirements
Module: dvp_pixel_packer

Interface
REQ-001 SHALL have parameter PIXCNT_W, default 12, width of per-line pixel counter.
REQ-002 SHALL have parameter LINECNT_W, default 11, width of per-frame line counter.
REQ-003 SHALL have port clk  in  1  DVP pixel clock; sole clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port dvp_data  in  8  camera byte.
REQ-006 SHALL have port dvp_href  in  1  line-valid, active high.
REQ-007 SHALL have port dvp_vsync  in  1  frame sync, active high.
REQ-008 SHALL have port cap_enable  in  1  capture request level.
REQ-009 SHALL have port byte_swap  in  1  0: first byte of a pixel is bits 15:8; 1: bits 7:0.
REQ-010 SHALL have port out_data  out  32  packed word; pixel 0 in 15:0, pixel 1 in 31:16.
REQ-011 SHALL have port out_valid  out  1  one-cycle word strobe.
REQ-012 SHALL have port out_ready  in  1  downstream FIFO can accept (not full).
REQ-013 SHALL have port frame_start  out  1  one-cycle pulse, first line of a captured frame may follow.
REQ-014 SHALL have port frame_done  out  1  one-cycle pulse, captured frame ended.
REQ-015 SHALL have port overflow  out  1  sticky: a word was dropped.
REQ-016 SHALL have port ovf_clear  in  1  synchronous clear of overflow.
REQ-017 SHALL have port line_width  out  PIXCNT_W  pixel count of last completed line.
REQ-018 SHALL have port frame_lines  out  LINECNT_W  line count of last completed frame.

Function
REQ-019 SHALL register dvp_data, dvp_href, dvp_vsync once (stage S1); all edge detection on S1 vs previous S1.
REQ-020 SHALL implement states IDLE, SYNC, VBLANK, ACTIVE.
REQ-021 IDLE -> SYNC when cap_enable=1; SYNC -> VBLANK on vsync rising edge; VBLANK -> ACTIVE on vsync falling edge, frame_start pulsed same cycle; SYNC/VBLANK -> IDLE if cap_enable=0.
REQ-022 ACTIVE on vsync rising edge: frame_done pulsed, frame_lines latched; -> VBLANK if cap_enable=1 else IDLE; cap_enable drop mid-frame SHALL NOT abort the frame.
REQ-023 Bytes SHALL be accepted only in ACTIVE with S1 href=1; byte phase and pixel phase reset to 0 on href rising edge.
REQ-024 Each byte pair SHALL form one 16-bit pixel per byte_swap (sampled per pixel); dangling odd byte at href fall SHALL be discarded.
REQ-025 Word SHALL be emitted on completion of second pixel; out_valid high for exactly one cycle, registered, 1 clock after S1 holds final byte (2 clocks after byte on dvp_data).
REQ-026 On href falling edge with one pixel pending, SHALL emit word with bits 31:16 = 0 next cycle.
REQ-027 out_data SHALL hold last emitted word until next emission.
REQ-028 If out_valid=1 and out_ready=0 same cycle, word SHALL be dropped and overflow set; no stall, no retry.
REQ-029 ovf_clear SHALL clear overflow; simultaneous set and clear SHALL leave overflow=1.
REQ-030 Pixel counter SHALL count completed pixels per line, saturate at 2^PIXCNT_W-1, latch to line_width on href falling edge in ACTIVE.
REQ-031 Line counter SHALL increment on href falling edge in ACTIVE, saturate at 2^LINECNT_W-1, clear at frame_start.
REQ-032 href activity outside ACTIVE SHALL produce no words and no counter updates.

Reset
REQ-033 On reset_n=0 SHALL immediately enter IDLE; out_valid, frame_start, frame_done, overflow = 0; out_data, line_width, frame_lines, counters, S1 regs = 0.
REQ-034 Reset mid-line SHALL discard partial pixel/word; after release capture SHALL resume only via SYNC (next full vsync cycle).

Verification
REQ-035 Enable, vsync pulse, one line of 8 bytes 0x11..0x88, byte_swap=0, out_ready=1 -> words 0x33441122, 0x77885566; line_width=4; frame_done -> frame_lines=1.
REQ-036 Same line, byte_swap=1 -> words 0x44332211, 0x88776655.
REQ-037 Line of 6 bytes 0xA1..0xA6 -> 0xA3A4A1A2 then 0x0000A5A6 one cycle after href fall; 7 bytes -> identical output, seventh byte dropped; line_width=3.
REQ-038 out_ready=0 on one strobe -> that word absent, overflow=1 until ovf_clear; ovf_clear with concurrent drop -> overflow stays 1.
REQ-039 Enable asserted mid-frame (vsync low, href toggling) -> no output until vsync rise then fall; cap_enable dropped mid-frame -> frame completes, frame_done pulses, state IDLE.
REQ-040 reset_n pulsed after 3 bytes of a line -> all outputs 0, no word emitted for remaining bytes, next frame captured normally after full vsync cycle.
